// File: rtl/mask_centroid.sv
// Frame centroid of a 1-bit pixel mask: accumulates sum(x), sum(y) and the masked-pixel count, then divides.
// Latency: tabulate sampled at edge T -> valid_out high for the cycle after edge T+ACC_W+1 (busy_out high ACC_W+1 cycles).
// Backpressure: none; pixels are accepted every cycle, and a tabulate pulse arriving while busy is dropped (frames merge).
module mask_centroid #(
  parameter int H_W   = 11,
  parameter int V_W   = 10,
  parameter int ACC_W = 32   // must cover H_W+V_W+H_W so a full frame of x sums cannot wrap
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           valid_in,
  input  logic [H_W-1:0] x_in,
  input  logic [V_W-1:0] y_in,
  input  logic           mask_in,
  input  logic           tabulate_in,
  output logic [H_W-1:0] x_out,
  output logic [V_W-1:0] y_out,
  output logic           valid_out,
  output logic           busy_out
);

  localparam int CNT_W  = H_W + V_W;
  localparam int ACC_W1 = ACC_W + 1;
  localparam int BIT_W  = $clog2(ACC_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   sum_x_q, sum_x_d;
  logic [ACC_W-1:0]   sum_y_q, sum_y_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ACC_W-1:0]   quo_x_q, quo_x_d;
  logic [ACC_W-1:0]   quo_y_q, quo_y_d;
  logic [ACC_W-1:0]   rem_x_q, rem_x_d;
  logic [ACC_W-1:0]   rem_y_q, rem_y_d;
  logic [CNT_W-1:0]   divisor_q, divisor_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [H_W-1:0]     x_out_q, x_out_d;
  logic [V_W-1:0]     y_out_q, y_out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic               pix_hit;
  logic               accept;
  logic [ACC_W-1:0]   acc_x;
  logic [ACC_W-1:0]   acc_y;
  logic [CNT_W-1:0]   acc_cnt;

  // One restoring-division step: shift the next dividend bit into the remainder,
  // subtract the divisor if it fits, and shift the resulting quotient bit in.
  // The dividend is held in the quotient register and consumed MSB-first.
  function automatic logic [2*ACC_W-1:0] div_step(
    input logic [ACC_W-1:0] rem,
    input logic [ACC_W-1:0] quo,
    input logic [CNT_W-1:0] dvs
  );
    logic [ACC_W:0]   trial;
    logic [ACC_W:0]   dext;
    logic [ACC_W-1:0] diff;
    trial = {rem, quo[ACC_W-1]};
    dext  = ACC_W1'(dvs);
    diff  = ACC_W'(trial - dext);
    if (trial >= dext) begin
      return {diff, quo[ACC_W-2:0], 1'b1};
    end else begin
      return {trial[ACC_W-1:0], quo[ACC_W-2:0], 1'b0};
    end
  endfunction

  // Frame totals including the pixel presented this cycle; this is what a
  // tabulate in this cycle snapshots, so a same-cycle pixel lands in the old frame.
  always_comb begin
    pix_hit = valid_in & mask_in;
    acc_x   = sum_x_q + (pix_hit ? ACC_W'(x_in) : '0);
    acc_y   = sum_y_q + (pix_hit ? ACC_W'(y_in) : '0);
    acc_cnt = count_q + CNT_W'(pix_hit);
    accept  = tabulate_in && (state_q == IDLE);
  end

  // Next-state logic: accumulators, divider datapath, FSM and registered outputs.
  always_comb begin
    state_d   = state_q;
    sum_x_d   = acc_x;
    sum_y_d   = acc_y;
    count_d   = acc_cnt;
    quo_x_d   = quo_x_q;
    quo_y_d   = quo_y_q;
    rem_x_d   = rem_x_q;
    rem_y_d   = rem_y_q;
    divisor_d = divisor_q;
    bit_d     = bit_q;
    x_out_d   = x_out_q;
    y_out_d   = y_out_q;
    valid_d   = 1'b0;

    // An accepted tabulate restarts the frame even when it was empty; a
    // tabulate while busy falls through and the frame keeps accumulating.
    if (accept) begin
      sum_x_d = '0;
      sum_y_d = '0;
      count_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (accept && (acc_cnt != '0)) begin
          quo_x_d   = acc_x;
          quo_y_d   = acc_y;
          rem_x_d   = '0;
          rem_y_d   = '0;
          divisor_d = acc_cnt;
          bit_d     = BIT_W'(ACC_W - 1);
          state_d   = DIVIDE;
        end
      end
      DIVIDE: begin
        {rem_x_d, quo_x_d} = div_step(rem_x_q, quo_x_q, divisor_q);
        {rem_y_d, quo_y_d} = div_step(rem_y_q, quo_y_q, divisor_q);
        bit_d = bit_q - BIT_W'(1);
        if (bit_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // A centroid cannot exceed the largest coordinate, so truncation is lossless.
        x_out_d = quo_x_q[H_W-1:0];
        y_out_d = quo_y_q[V_W-1:0];
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State registers; reset also aborts any division in flight.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      sum_x_q   <= '0;
      sum_y_q   <= '0;
      count_q   <= '0;
      quo_x_q   <= '0;
      quo_y_q   <= '0;
      rem_x_q   <= '0;
      rem_y_q   <= '0;
      divisor_q <= '0;
      bit_q     <= '0;
      x_out_q   <= '0;
      y_out_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_x_q   <= sum_x_d;
      sum_y_q   <= sum_y_d;
      count_q   <= count_d;
      quo_x_q   <= quo_x_d;
      quo_y_q   <= quo_y_d;
      rem_x_q   <= rem_x_d;
      rem_y_q   <= rem_y_d;
      divisor_q <= divisor_d;
      bit_q     <= bit_d;
      x_out_q   <= x_out_d;
      y_out_q   <= y_out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign valid_out = valid_q;
  assign busy_out  = busy_q;

endmodule
